// File: rtl/binary_div_24_12_seq_if.sv
// binary_div_24_12_seq_if: enable, start/operand and result/status bundle of the sequential divider
interface binary_div_24_12_seq_if #(parameter int DW = 12);
  localparam int PW = 2 * DW;
  logic en;
  logic start;
  logic [PW-1:0] P;
  logic [DW-1:0] B;
  logic [PW-1:0] Q;
  logic [DW-1:0] R;
  logic busy;
  logic done;
  logic ovf;
  logic dz;
  modport master (output en, start, P, B, input Q, R, busy, done, ovf, dz);
  modport slave (input en, start, P, B, output Q, R, busy, done, ovf, dz);
endinterface

// File: rtl/binary_div_24_12_seq.sv
// binary_div_24_12_seq: unsigned restoring divider, 24-bit dividend by 12-bit divisor, one quotient bit per enabled clock
module binary_div_24_12_seq #(parameter int DW = 12) (
  input logic clk,
  input logic rst,
  binary_div_24_12_seq_if.slave bus
);
  localparam int PW = 2 * DW;
  localparam int CW = $clog2(PW + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0] rem_q, rem_d, shf, dif;
  logic [PW-1:0] dvd_q, dvd_d, q_q, q_d;
  logic [DW-1:0] b_q, b_d, r_q, r_d;
  logic ovf_q, ovf_d, dz_q, dz_d, ge;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      b_q <= '0;
      q_q <= '0;
      r_q <= '0;
      ovf_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      b_q <= b_d;
      q_q <= q_d;
      r_q <= r_d;
      ovf_q <= ovf_d;
      dz_q <= dz_d;
    end
  end
  // a bit shifted out of the top of rem already makes the trial value exceed B
  always_comb begin
    shf = {rem_q[DW-1:0], dvd_q[PW-1]};
    ge = rem_q[DW] | (shf >= {1'b0, b_q});
    dif = shf - {1'b0, b_q};
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    dvd_d = dvd_q;
    b_d = b_q;
    q_d = q_q;
    r_d = r_q;
    ovf_d = ovf_q;
    dz_d = dz_q;
    if (bus.en) begin
      if (state_q == IDLE && bus.start) begin
        dvd_d = bus.P;
        b_d = bus.B;
        rem_d = '0;
        cnt_d = CW'(PW);
        ovf_d = bus.B == '0;
        dz_d = bus.B == '0;
        state_d = bus.B == '0 ? DONE : CALC;
        q_d = bus.B == '0 ? '1 : q_q;
        r_d = bus.B == '0 ? bus.P[DW-1:0] : r_q;
      end else if (state_q == CALC) begin
        rem_d = ge ? dif : shf;
        dvd_d = {dvd_q[PW-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          q_d = dvd_d;
          r_d = rem_d[DW-1:0];
          ovf_d = |dvd_d[PW-1:DW];
          dz_d = 1'b0;
        end
      end else if (state_q == DONE) begin
        state_d = IDLE;
      end
    end
  end
  assign bus.Q = q_q;
  assign bus.R = r_q;
  assign bus.busy = state_q == CALC;
  assign bus.done = state_q == DONE;
  assign bus.ovf = ovf_q;
  assign bus.dz = dz_q;
endmodule

// File: tb/tb_binary_div_24_12_seq.sv
// tb_binary_div_24_12_seq: directed vectors with a result scoreboard checked by an independent done monitor
module tb_binary_div_24_12_seq;
  typedef struct packed {
    logic [23:0] q;
    logic [11:0] r;
    logic o;
    logic z;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  binary_div_24_12_seq_if bus();
  binary_div_24_12_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic run(input logic [23:0] p, input logic [11:0] b, input logic [23:0] eq, input logic [11:0] er,
                     input logic eo, input logic ez, input int exp_edges, input int gap_at, input int gap_len,
                     input int restart_at, input bit hold_done);
    int n;
    bit seen;
    @(negedge clk);
    bus.P = p;
    bus.B = b;
    bus.start = 1'b1;
    exp_q.push_back('{eq, er, eo, ez});
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.start = n == restart_at;
      if (n == restart_at) begin
        bus.P = 24'd1;
        bus.B = 12'd1;
      end
      bus.en = !(n >= gap_at && n < gap_at + gap_len);
      if (n == 1) chk("busy_after_start", bus.busy, !ez);
      seen = bus.done;
    end
    chk("latency_edges", n, exp_edges);
    if (hold_done) begin
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      chk("done_held_en_low", bus.done, 1);
      bus.en = 1'b1;
      @(negedge clk);
      chk("done_cleared_after_en", bus.done, 0);
    end
  endtask
  initial begin : monitor
    bit prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pending result");
        end else begin
          e = exp_q.pop_front();
          chk("Q", bus.Q, e.q);
          chk("R", bus.R, e.r);
          chk("ovf", bus.ovf, e.o);
          chk("dz", bus.dz, e.z);
        end
      end
      prev = bus.done;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.en = 1'b1;
    bus.start = 1'b0;
    bus.P = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    chk("rst_Q", bus.Q, 0);
    chk("rst_R", bus.R, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_dz", bus.dz, 0);
    rst = 1'b0;
    run(24'd699678, 12'd567, 24'd1234, 12'd0, 0, 0, 25, 0, 0, 0, 0);
    run(24'd699778, 12'd567, 24'd1234, 12'd100, 0, 0, 25, 0, 0, 0, 0);
    run(24'd16769025, 12'd1, 24'd16769025, 12'd0, 1, 0, 25, 0, 0, 0, 0);
    run(24'd16769025, 12'd2, 24'd8384512, 12'd1, 1, 0, 25, 0, 0, 0, 0);
    run(24'd16769025, 12'd4095, 24'd4095, 12'd0, 0, 0, 25, 0, 0, 0, 0);
    run(24'hFFFFFF, 12'd1, 24'd16777215, 12'd0, 1, 0, 25, 0, 0, 0, 0);
    run(24'd5, 12'd4095, 24'd0, 12'd5, 0, 0, 25, 0, 0, 0, 0);
    run(24'd1000, 12'd0, 24'hFFFFFF, 12'd1000, 1, 1, 1, 0, 0, 0, 0);
    run(24'd699678, 12'd567, 24'd1234, 12'd0, 0, 0, 25, 0, 0, 10, 0);
    @(negedge clk);
    bus.P = 24'd699678;
    bus.B = 12'd567;
    bus.start = 1'b1;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_Q", bus.Q, 0);
    chk("async_rst_R", bus.R, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_ovf", bus.ovf, 0);
    chk("async_rst_dz", bus.dz, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("idle_after_rst", bus.busy, 0);
    run(24'd123456, 12'd100, 24'd1234, 12'd56, 0, 0, 25, 0, 0, 0, 0);
    run(24'd699778, 12'd567, 24'd1234, 12'd100, 0, 0, 32, 5, 7, 0, 0);
    run(24'd16769025, 12'd4095, 24'd4095, 12'd0, 0, 0, 25, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
